// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the front-end hazard/flush sequencer.
package pipe_ctrl_pkg;

  localparam int XLEN_DEF = 64;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_STALL      = 2'd1,
    ST_REDIRECT   = 2'd2,
    ST_TRAP_DRAIN = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic enable;
    logic flush;
  } stage_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and flush sequencer: drives PC and stage-register enable/flush controls.
//   state         | meaning
//   RUN           | normal issue; load-use and fetch bubbles handled in place
//   STALL         | back end busy, whole front end frozen
//   REDIRECT      | one cycle after a PC redirect, kills wrong-path fetch
//   TRAP_DRAIN    | draining back end before issuing the trap vector
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int XLEN         = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_use_hazard,
  input  logic            ex_busy,
  input  logic            mem_busy,
  input  logic            fetch_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  output logic            pc_enable,
  output logic            pc_redirect_valid,
  output logic [XLEN-1:0] pc_redirect_target,
  output logic            fd_enable,
  output logic            fd_flush,
  output logic            de_enable,
  output logic            de_flush,
  output logic [1:0]      ctrl_state,
  output logic [31:0]     stall_cycles
);

  ctrl_state_t     state, state_nxt;
  logic [3:0]      drain_cnt, drain_nxt;
  logic [XLEN-1:0] vec_q, vec_nxt;
  stage_ctrl_t     fd_c, de_c;
  logic            stall_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      vec_q     <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      vec_q     <= vec_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    drain_nxt          = drain_cnt;
    vec_nxt            = vec_q;
    pc_enable          = 1'b1;
    pc_redirect_valid  = 1'b0;
    pc_redirect_target = '0;
    fd_c               = '{enable: 1'b1, flush: 1'b0};
    de_c               = '{enable: 1'b1, flush: 1'b0};

    if (state == ST_TRAP_DRAIN) begin
      fd_c      = '{enable: 1'b0, flush: 1'b1};
      de_c      = '{enable: 1'b0, flush: 1'b1};
      pc_enable = 1'b0;
      if (drain_cnt == 4'd0) begin
        pc_redirect_valid  = 1'b1;
        pc_redirect_target = vec_q;
        pc_enable          = 1'b1;
        state_nxt          = ST_REDIRECT;
      end else begin
        drain_nxt = drain_cnt - 4'd1;
      end
    end else if (trap_valid) begin
      vec_nxt   = trap_vec;
      drain_nxt = 4'(DRAIN_CYCLES - 1);
      fd_c      = '{enable: 1'b0, flush: 1'b1};
      de_c      = '{enable: 1'b0, flush: 1'b1};
      pc_enable = 1'b0;
      state_nxt = ST_TRAP_DRAIN;
    end else if (redirect_valid) begin
      pc_redirect_valid  = 1'b1;
      pc_redirect_target = redirect_pc;
      fd_c               = '{enable: 1'b0, flush: 1'b1};
      de_c               = '{enable: 1'b0, flush: 1'b1};
      state_nxt          = ST_REDIRECT;
    end else if (state == ST_REDIRECT) begin
      fd_c      = '{enable: 1'b0, flush: 1'b1};
      state_nxt = ST_RUN;
    end else if (ex_busy || mem_busy) begin
      // RUN and STALL share the same priority ladder; only busy keeps us in STALL
      pc_enable = 1'b0;
      fd_c      = '{enable: 1'b0, flush: 1'b0};
      de_c      = '{enable: 1'b0, flush: 1'b0};
      state_nxt = ST_STALL;
    end else if (load_use_hazard) begin
      pc_enable = 1'b0;
      fd_c      = '{enable: 1'b0, flush: 1'b0};
      de_c      = '{enable: 1'b0, flush: 1'b1};
      state_nxt = ST_RUN;
    end else if (!fetch_ready) begin
      pc_enable = 1'b0;
      fd_c      = '{enable: 1'b0, flush: 1'b1};
      state_nxt = ST_RUN;
    end else begin
      state_nxt = ST_RUN;
    end

    if (!rst) begin
      pc_enable          = 1'b0;
      pc_redirect_valid  = 1'b0;
      pc_redirect_target = '0;
      fd_c               = '{enable: 1'b0, flush: 1'b1};
      de_c               = '{enable: 1'b0, flush: 1'b1};
    end
  end

  assign fd_enable  = fd_c.enable;
  assign fd_flush   = fd_c.flush;
  assign de_enable  = de_c.enable;
  assign de_flush   = de_c.flush;
  assign ctrl_state = state;

  assign stall_inc = !pc_enable && ((state == ST_RUN) || (state == ST_STALL));

  sat_counter #(.WIDTH(32)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus random traffic vs a behavioural model.
module tb_pipeline_ctrl;

  localparam int DRAIN = 3;
  localparam int XW    = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_use_hazard, ex_busy, mem_busy, fetch_ready;
  logic          redirect_valid, trap_valid;
  logic [XW-1:0] redirect_pc, trap_vec;
  logic          pc_enable, pc_redirect_valid, fd_enable, fd_flush, de_enable, de_flush;
  logic [XW-1:0] pc_redirect_target;
  logic [1:0]    ctrl_state;
  logic [31:0]   stall_cycles;

  int n_vec = 0;
  int n_err = 0;

  // model: drain_left < 0 means no trap pending
  int          drain_left;
  bit          after_redir;
  bit          stalled;
  logic [63:0] vec_m;
  logic [31:0] cnt_m;

  always #5 clk = ~clk;

  pipeline_ctrl #(.DRAIN_CYCLES(DRAIN), .XLEN(XW)) dut (
    .clk                (clk),
    .rst                (rst),
    .load_use_hazard    (load_use_hazard),
    .ex_busy            (ex_busy),
    .mem_busy           (mem_busy),
    .fetch_ready        (fetch_ready),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .trap_valid         (trap_valid),
    .trap_vec           (trap_vec),
    .pc_enable          (pc_enable),
    .pc_redirect_valid  (pc_redirect_valid),
    .pc_redirect_target (pc_redirect_target),
    .fd_enable          (fd_enable),
    .fd_flush           (fd_flush),
    .de_enable          (de_enable),
    .de_flush           (de_flush),
    .ctrl_state         (ctrl_state),
    .stall_cycles       (stall_cycles)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] ctl_now();
    return {pc_enable, pc_redirect_valid, fd_enable, fd_flush, de_enable, de_flush};
  endfunction

  task automatic model_reset();
    drain_left  = -1;
    after_redir = 1'b0;
    stalled     = 1'b0;
    vec_m       = '0;
    cnt_m       = '0;
  endtask

  // one clock: drive inputs, compare against the model at negedge, advance model
  task automatic step(input bit lu, input bit exb, input bit meb, input bit fr,
                      input bit rv, input logic [63:0] rpc, input bit tv, input logic [63:0] tvec);
    logic [5:0]  e;
    logic [63:0] tgt;
    logic [1:0]  est;
    @(posedge clk);
    #1;
    load_use_hazard = lu;  ex_busy = exb; mem_busy = meb; fetch_ready = fr;
    redirect_valid  = rv;  redirect_pc = rpc; trap_valid = tv; trap_vec = tvec;
    @(negedge clk);
    tgt = '0;
    est = (drain_left >= 0) ? 2'd3 : after_redir ? 2'd2 : stalled ? 2'd1 : 2'd0;
    if (drain_left == 0) begin
      e = 6'b110101; tgt = vec_m; drain_left = -1; after_redir = 1'b1;
    end else if (drain_left > 0) begin
      e = 6'b000101; drain_left--;
    end else if (tv) begin
      e = 6'b000101; vec_m = tvec; drain_left = DRAIN - 1; after_redir = 1'b0; stalled = 1'b0;
    end else if (rv) begin
      e = 6'b110101; tgt = rpc; after_redir = 1'b1; stalled = 1'b0;
    end else if (after_redir) begin
      e = 6'b100110; after_redir = 1'b0;
    end else if (exb || meb) begin
      e = 6'b000000; stalled = 1'b1;
    end else if (lu) begin
      e = 6'b000001; stalled = 1'b0;
    end else if (!fr) begin
      e = 6'b000110; stalled = 1'b0;
    end else begin
      e = 6'b101010; stalled = 1'b0;
    end
    check_eq("ctl", {58'd0, ctl_now()}, {58'd0, e});
    check_eq("state", {62'd0, ctrl_state}, {62'd0, est});
    check_eq("stall_cnt", {32'd0, stall_cycles}, {32'd0, cnt_m});
    if (e[4]) check_eq("target", pc_redirect_target, tgt);
    if (!e[5] && est <= 2'd1 && cnt_m != 32'hFFFF_FFFF) cnt_m++;
  endtask

  task automatic quiet();
    step(0, 0, 0, 1, 0, '0, 0, '0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    load_use_hazard = 1; ex_busy = 1; mem_busy = 1; fetch_ready = 1;
    redirect_valid = 1; redirect_pc = '1; trap_valid = 1; trap_vec = '1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_ctl", {58'd0, ctl_now()}, 64'b000101);
      check_eq("rst_cnt", {32'd0, stall_cycles}, 64'd0);
      check_eq("rst_state", {62'd0, ctrl_state}, 64'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    load_use_hazard = 0; ex_busy = 0; mem_busy = 0; redirect_valid = 0; trap_valid = 0;
  endtask

  initial begin
    rst = 1'b1;
    load_use_hazard = 0; ex_busy = 0; mem_busy = 0; fetch_ready = 1;
    redirect_valid = 0; redirect_pc = '0; trap_valid = 0; trap_vec = '0;
    model_reset();
    #2;
    do_reset();
    quiet();
    check_eq("release_en", {61'd0, pc_enable, fd_enable, de_enable}, 64'b111);

    // load-use bubble
    step(1, 0, 0, 1, 0, '0, 0, '0);
    quiet();
    check_eq("lu_cnt", {32'd0, stall_cycles}, 64'd1);

    // branch redirect
    step(0, 0, 0, 1, 1, 64'h8000_0100, 0, '0);
    check_eq("redir_tgt", pc_redirect_target, 64'h8000_0100);
    step(0, 0, 0, 1, 0, '0, 0, '0);
    check_eq("redir_fd2", {63'd0, fd_flush}, 64'd1);
    quiet();

    // trap beats concurrent and following redirects
    step(0, 0, 0, 1, 1, 64'h1234, 1, 64'h8000_0004);
    step(0, 0, 0, 1, 1, 64'h5678, 0, '0);
    quiet();
    quiet();
    check_eq("trap_rv", {63'd0, pc_redirect_valid}, 64'd1);
    check_eq("trap_tgt", pc_redirect_target, 64'h8000_0004);
    quiet();
    quiet();

    // busy freeze and same-cycle release
    begin
      logic [31:0] base;
      base = stall_cycles;
      for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 0, '0, 0, '0);
      check_eq("busy_state", {62'd0, ctrl_state}, 64'd1);
      quiet();
      check_eq("busy_cnt", {32'd0, stall_cycles - base}, 64'd5);
      check_eq("busy_rel_state", {62'd0, ctrl_state}, 64'd1);
      check_eq("busy_rel_en", {58'd0, ctl_now()}, 64'b101010);
    end

    // reset mid-drain abandons the trap
    step(0, 0, 0, 1, 0, '0, 1, 64'hDEAD_0000);
    quiet();
    do_reset();
    for (int i = 0; i < 4; i++) quiet();

    // saturation
    @(posedge clk);
    #1;
    force dut.u_stall_cnt.count = 32'hFFFF_FFFE;
    #1;
    release dut.u_stall_cnt.count;
    cnt_m = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, '0, 0, '0);
    quiet();
    check_eq("sat_cnt", {32'd0, stall_cycles}, 64'hFFFF_FFFF);
    do_reset();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 85,
           $urandom_range(0, 99) < 10, {$urandom, $urandom},
           $urandom_range(0, 99) < 4, {$urandom, $urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
